// File: rtl/tron_pkg.sv
// Shared constants, owner codes and FSM encoding for the Tron cell-occupancy store.
package tron_pkg;

    localparam int unsigned GRID_COLS       = 40;
    localparam int unsigned GRID_ROWS       = 30;
    localparam int unsigned GRID_CELL_SHIFT = 4;

    localparam logic [1:0] OWN_EMPTY = 2'b00;
    localparam logic [1:0] OWN_P1    = 2'b01;
    localparam logic [1:0] OWN_P2    = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RD1,
        S_RD2,
        S_EVAL,
        S_WR1,
        S_WR2,
        S_DONE
    } state_t;

    function automatic logic [15:0] cell_index(input logic [15:0] row,
                                               input logic [15:0] col,
                                               input logic [15:0] cols);
        return row * cols + col;
    endfunction

endpackage

// File: rtl/tron_cell_ram.sv
// Simple dual-port 2-bit cell RAM: read/write game port A, read-only pixel port B.
module tron_cell_ram #(
    parameter int unsigned DEPTH  = 1200,
    parameter int unsigned ADDR_W = 11
) (
    input  logic              clk,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [1:0]        wdata_a,
    output logic [1:0]        rdata_a,
    input  logic [ADDR_W-1:0] addr_b,
    output logic [1:0]        rdata_b
);

    logic [1:0] mem [DEPTH];

    // No reset on contents or read registers so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we_a) begin
            mem[addr_a] <= wdata_a;
        end
        rdata_a <= mem[addr_a];
    end

    always_ff @(posedge clk) begin
        rdata_b <= mem[addr_b];
    end

endmodule

// File: rtl/tron_trail_map.sv
// Tron playfield occupancy store: records both trails, evaluates crashes per game
// step, sweeps itself clear, and serves cell owners to the VGA colour stage.
module tron_trail_map
    import tron_pkg::*;
#(
    parameter int unsigned COLS       = GRID_COLS,
    parameter int unsigned ROWS       = GRID_ROWS,
    parameter int unsigned CELL_SHIFT = GRID_CELL_SHIFT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       clear_req,
    input  logic [5:0] p1_col,
    input  logic [4:0] p1_row,
    input  logic [5:0] p2_col,
    input  logic [4:0] p2_row,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    output logic [1:0] pix_owner,
    output logic       busy,
    output logic       step_done,
    output logic       p1_crash,
    output logic       p2_crash,
    output logic       tick_overrun
);

    localparam int unsigned CELLS  = COLS * ROWS;
    localparam int unsigned ADDR_W = $clog2(CELLS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
    localparam logic [5:0] COLS_L = 6'(COLS);
    localparam logic [4:0] ROWS_L = 5'(ROWS);
    localparam logic [9:0] PIX_W  = 10'(COLS << CELL_SHIFT);
    localparam logic [9:0] PIX_H  = 10'(ROWS << CELL_SHIFT);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] sweep_q, sweep_d;
    logic [5:0]        h1_col_q, h1_col_d, h2_col_q, h2_col_d;
    logic [4:0]        h1_row_q, h1_row_d, h2_row_q, h2_row_d;
    logic [1:0]        p1_cell_q, p1_cell_d;
    logic              p1c_q, p1c_d, p2c_q, p2c_d;
    logic              p1_crash_q, p1_crash_d, p2_crash_q, p2_crash_d;
    logic              ovr_q, ovr_d;
    logic              clr_pend_q, clr_pend_d;
    logic              step_done_q, step_done_d;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [1:0]        ram_wdata, ram_rdata, pix_rdata;

    logic              pix_area_q, pix_area_q2;
    logic [ADDR_W-1:0] pix_addr_q;

    logic              h1_oob, h2_oob, heads_eq;
    logic [ADDR_W-1:0] h1_addr, h2_addr;

    assign h1_oob   = (h1_col_q >= COLS_L) || (h1_row_q >= ROWS_L);
    assign h2_oob   = (h2_col_q >= COLS_L) || (h2_row_q >= ROWS_L);
    assign heads_eq = (h1_col_q == h2_col_q) && (h1_row_q == h2_row_q);
    assign h1_addr  = h1_oob ? '0 : ADDR_W'(cell_index(16'(h1_row_q), 16'(h1_col_q), 16'(COLS)));
    assign h2_addr  = h2_oob ? '0 : ADDR_W'(cell_index(16'(h2_row_q), 16'(h2_col_q), 16'(COLS)));

    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        h1_col_d    = h1_col_q;
        h1_row_d    = h1_row_q;
        h2_col_d    = h2_col_q;
        h2_row_d    = h2_row_q;
        p1_cell_d   = p1_cell_q;
        p1c_d       = p1c_q;
        p2c_d       = p2c_q;
        p1_crash_d  = p1_crash_q;
        p2_crash_d  = p2_crash_q;
        ovr_d       = ovr_q;
        clr_pend_d  = clr_pend_q;
        step_done_d = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = '0;
        ram_wdata   = OWN_EMPTY;

        if (tick && state_q != S_IDLE) begin
            ovr_d = 1'b1;
        end
        if (clear_req && state_q != S_IDLE && state_q != S_CLEAR) begin
            clr_pend_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (clear_req) begin
                    sweep_d    = '0;
                    state_d    = S_CLEAR;
                    p1_crash_d = 1'b0;
                    p2_crash_d = 1'b0;
                    ovr_d      = 1'b0;
                end else if (tick) begin
                    h1_col_d = p1_col;
                    h1_row_d = p1_row;
                    h2_col_d = p2_col;
                    h2_row_d = p2_row;
                    state_d  = S_RD1;
                end
            end
            S_CLEAR: begin
                ram_we   = 1'b1;
                ram_addr = sweep_q;
                if (clear_req) begin
                    sweep_d    = '0;
                    p1_crash_d = 1'b0;
                    p2_crash_d = 1'b0;
                    ovr_d      = 1'b0;
                end else if (sweep_q == LAST_ADDR) begin
                    state_d = S_IDLE;
                end else begin
                    sweep_d = sweep_q + 1'b1;
                end
            end
            S_RD1: begin
                ram_addr = h1_addr;
                state_d  = S_RD2;
            end
            // P1 cell data lands during RD2, P2 cell data during EVAL.
            S_RD2: begin
                ram_addr  = h2_addr;
                p1_cell_d = ram_rdata;
                state_d   = S_EVAL;
            end
            S_EVAL: begin
                p1c_d   = h1_oob || (p1_cell_q != OWN_EMPTY) || heads_eq;
                p2c_d   = h2_oob || (ram_rdata != OWN_EMPTY) || heads_eq;
                state_d = S_WR1;
            end
            S_WR1: begin
                ram_we    = !h1_oob;
                ram_addr  = h1_addr;
                ram_wdata = OWN_P1;
                state_d   = S_WR2;
            end
            S_WR2: begin
                ram_we    = !h2_oob;
                ram_addr  = h2_addr;
                ram_wdata = OWN_P2;
                state_d   = S_DONE;
            end
            S_DONE: begin
                step_done_d = 1'b1;
                p1_crash_d  = p1c_q;
                p2_crash_d  = p2c_q;
                if (clr_pend_q || clear_req) begin
                    clr_pend_d = 1'b0;
                    sweep_d    = '0;
                    ovr_d      = 1'b0;
                    state_d    = S_CLEAR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_CLEAR;
            sweep_q     <= '0;
            h1_col_q    <= '0;
            h1_row_q    <= '0;
            h2_col_q    <= '0;
            h2_row_q    <= '0;
            p1_cell_q   <= OWN_EMPTY;
            p1c_q       <= 1'b0;
            p2c_q       <= 1'b0;
            p1_crash_q  <= 1'b0;
            p2_crash_q  <= 1'b0;
            ovr_q       <= 1'b0;
            clr_pend_q  <= 1'b0;
            step_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            h1_col_q    <= h1_col_d;
            h1_row_q    <= h1_row_d;
            h2_col_q    <= h2_col_d;
            h2_row_q    <= h2_row_d;
            p1_cell_q   <= p1_cell_d;
            p1c_q       <= p1c_d;
            p2c_q       <= p2c_d;
            p1_crash_q  <= p1_crash_d;
            p2_crash_q  <= p2_crash_d;
            ovr_q       <= ovr_d;
            clr_pend_q  <= clr_pend_d;
            step_done_q <= step_done_d;
        end
    end

    // Off-screen beam positions are steered to address 0; the area flag masks the data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_area_q  <= 1'b0;
            pix_area_q2 <= 1'b0;
            pix_addr_q  <= '0;
        end else begin
            pix_area_q  <= (pix_x < PIX_W) && (pix_y < PIX_H);
            pix_area_q2 <= pix_area_q;
            pix_addr_q  <= ((pix_x < PIX_W) && (pix_y < PIX_H))
                         ? ADDR_W'(cell_index(16'(pix_y >> CELL_SHIFT), 16'(pix_x >> CELL_SHIFT), 16'(COLS)))
                         : '0;
        end
    end

    tron_cell_ram #(
        .DEPTH (CELLS),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk    (clk),
        .we_a   (ram_we),
        .addr_a (ram_addr),
        .wdata_a(ram_wdata),
        .rdata_a(ram_rdata),
        .addr_b (pix_addr_q),
        .rdata_b(pix_rdata)
    );

    assign pix_owner    = pix_area_q2 ? pix_rdata : OWN_EMPTY;
    assign busy         = (state_q != S_IDLE);
    assign step_done    = step_done_q;
    assign p1_crash     = p1_crash_q;
    assign p2_crash     = p2_crash_q;
    assign tick_overrun = ovr_q;

endmodule

// File: tb/tb_tron_trail_map.sv
// Scoreboard bench for tron_trail_map: step results and pixel reads are queued at
// issue time and checked by a monitor when step_done or a probe reaches the output.
module tb_tron_trail_map;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       clear_req;
    logic [5:0] p1_col, p2_col;
    logic [4:0] p1_row, p2_row;
    logic [9:0] pix_x, pix_y;
    logic [1:0] pix_owner;
    logic       busy, step_done, p1_crash, p2_crash, tick_overrun;

    int total = 0;
    int bad   = 0;

    logic [1:0] exp_step[$];
    logic [1:0] exp_pix[$];
    logic       probe_v = 1'b0;
    logic       pv1 = 1'b0;
    logic       pv2 = 1'b0;

    always #5 clk = ~clk;

    tron_trail_map #(
        .COLS      (40),
        .ROWS      (30),
        .CELL_SHIFT(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .clear_req   (clear_req),
        .p1_col      (p1_col),
        .p1_row      (p1_row),
        .p2_col      (p2_col),
        .p2_row      (p2_row),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_owner   (pix_owner),
        .busy        (busy),
        .step_done   (step_done),
        .p1_crash    (p1_crash),
        .p2_crash    (p2_crash),
        .tick_overrun(tick_overrun)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        pv1 <= probe_v;
        pv2 <= pv1;
    end

    // Monitor: consumes the scoreboard whenever the DUT presents a result.
    always @(negedge clk) begin
        if (!reset) begin
            if (step_done) begin
                if (exp_step.size() == 0) begin
                    chk("unexpected_step_done", 1, 0);
                end else begin
                    logic [1:0] e;
                    e = exp_step.pop_front();
                    chk("p1_crash", int'(p1_crash), int'(e[1]));
                    chk("p2_crash", int'(p2_crash), int'(e[0]));
                end
            end
            if (pv2) begin
                if (exp_pix.size() == 0) begin
                    chk("unexpected_pixel", 1, 0);
                end else begin
                    logic [1:0] e;
                    e = exp_pix.pop_front();
                    chk("pix_owner", int'(pix_owner), int'(e));
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    task automatic count_busy(input string name, input int want);
        int n = 0;
        @(negedge clk);
        while (busy && n < 3000) begin
            n++;
            @(negedge clk);
        end
        chk(name, n, want);
    endtask

    task automatic probe(input int x, input int y, input logic [1:0] e);
        @(posedge clk);
        #1;
        pix_x   = 10'(x);
        pix_y   = 10'(y);
        probe_v = 1'b1;
        exp_pix.push_back(e);
    endtask

    task automatic probe_end();
        @(posedge clk);
        #1;
        probe_v = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic scan_empty();
        for (int r = 0; r < 30; r++) begin
            for (int c = 0; c < 40; c++) begin
                probe(c * 16 + (c % 16), r * 16 + ((r * 3) % 16), 2'b00);
            end
        end
        probe(700, 10, 2'b00);
        probe(100, 500, 2'b00);
        probe_end();
    endtask

    task automatic set_heads(input int c1, input int r1, input int c2, input int r2);
        p1_col = 6'(c1);
        p1_row = 5'(r1);
        p2_col = 6'(c2);
        p2_row = 5'(r2);
    endtask

    task automatic do_tick(input int c1, input int r1, input int c2, input int r2,
                           input logic e1, input logic e2);
        int n = 0;
        wait_idle();
        @(posedge clk);
        #1;
        set_heads(c1, r1, c2, r2);
        tick = 1'b1;
        exp_step.push_back({e1, e2});
        @(posedge clk);
        #1;
        tick = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (!step_done && n < 20);
        chk("step_latency", n, 7);
    endtask

    task automatic pulse_clear_count(input string name);
        @(posedge clk);
        #1;
        clear_req = 1'b1;
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        count_busy(name, 1200);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        tick      = 1'b0;
        clear_req = 1'b0;
        set_heads(0, 0, 0, 0);
        pix_x = '0;
        pix_y = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy), 1);
        chk("rst_pix_owner", int'(pix_owner), 0);
        chk("rst_step_done", int'(step_done), 0);
        chk("rst_p1_crash", int'(p1_crash), 0);
        chk("rst_p2_crash", int'(p2_crash), 0);
        chk("rst_overrun", int'(tick_overrun), 0);

        @(posedge clk);
        #1;
        reset = 1'b0;
        count_busy("reset_sweep_len", 1200);
        scan_empty();

        do_tick(5, 5, 20, 10, 1'b0, 1'b0);
        probe(80, 80, 2'b01);
        probe(95, 95, 2'b01);
        probe(87, 90, 2'b01);
        probe(320, 160, 2'b10);
        probe(79, 80, 2'b00);
        probe_end();

        do_tick(5, 5, 21, 10, 1'b1, 1'b0);
        probe(85, 85, 2'b01);
        probe(336, 160, 2'b10);
        probe_end();
        chk("p1_crash_held", int'(p1_crash), 1);

        do_tick(12, 12, 12, 12, 1'b1, 1'b1);
        probe(192, 192, 2'b10);
        probe_end();

        do_tick(40, 29, 22, 10, 1'b1, 1'b0);
        probe(639, 479, 2'b00);
        probe(352, 160, 2'b10);
        probe(0, 0, 2'b00);
        probe_end();

        do_tick(6, 6, 3, 30, 1'b0, 1'b1);
        probe(96, 96, 2'b01);
        probe(48, 464, 2'b00);
        probe_end();

        do_tick(39, 29, 0, 0, 1'b0, 1'b0);
        probe(639, 479, 2'b01);
        probe(0, 0, 2'b10);
        probe(640, 479, 2'b00);
        probe_end();

        chk("overrun_before", int'(tick_overrun), 0);
        wait_idle();
        @(posedge clk);
        #1;
        set_heads(1, 1, 2, 2);
        tick = 1'b1;
        exp_step.push_back(2'b00);
        @(posedge clk);
        #1;
        tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        set_heads(3, 3, 4, 4);
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        wait_idle();
        repeat (4) @(posedge clk);
        chk("overrun_set", int'(tick_overrun), 1);
        probe(16, 16, 2'b01);
        probe(32, 32, 2'b10);
        probe(48, 48, 2'b00);
        probe(64, 64, 2'b00);
        probe_end();

        pulse_clear_count("clear_sweep_len");
        chk("overrun_cleared", int'(tick_overrun), 0);
        chk("clear_p1_crash", int'(p1_crash), 0);
        scan_empty();

        wait_idle();
        @(posedge clk);
        #1;
        set_heads(7, 7, 8, 8);
        tick = 1'b1;
        exp_step.push_back(2'b00);
        @(posedge clk);
        #1;
        tick = 1'b0;
        @(posedge clk);
        #1;
        clear_req = 1'b1;
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!step_done && n < 20);
            chk("pend_step_seen", int'(step_done), 1);
            chk("pend_busy", int'(busy), 1);
            n = 0;
            while (busy && n < 3000) begin
                n++;
                @(negedge clk);
            end
            chk("pend_sweep_len", n, 1200);
        end
        probe(112, 112, 2'b00);
        probe(128, 128, 2'b00);
        probe_end();

        @(posedge clk);
        #1;
        clear_req = 1'b1;
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        repeat (100) @(posedge clk);
        pulse_clear_count("restart_sweep_len");

        @(posedge clk);
        #1;
        clear_req = 1'b1;
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        repeat (500) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midreset_busy", int'(busy), 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        count_busy("midreset_sweep_len", 1200);

        repeat (5) @(posedge clk);
        chk("step_queue_drained", exp_step.size(), 0);
        chk("pix_queue_drained", exp_pix.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tron_trail_map.md
Name: tron_trail_map

Overview:
- Cell-occupancy store for the Tron playfield. It sits between the player position/direction logic, which supplies the head cells on each game tick, and the VGA colour stage, which reads the owner of the cell under the beam.
- Records both light-cycle trails, detects crashes each game step, and sweeps itself clear on reset and on round restart.
- Dual-port cell RAM: a game port driven by an internal FSM, and a read-only pixel port.

Parameters:
- COLS, 40, playfield width in cells.
- ROWS, 30, playfield height in cells.
- CELL_SHIFT, 4, log2 of cell edge in pixels (16 px cells give 640x480).

Ports:
- clk  in  1  pixel-domain clock
- reset  in  1  asynchronous, active-high
- tick  in  1  one-cycle game-step pulse
- clear_req  in  1  one-cycle pulse; start a round-clear sweep
- p1_col  in  6  player 1 head column
- p1_row  in  5  player 1 head row
- p2_col  in  6  player 2 head column
- p2_row  in  5  player 2 head row
- pix_x  in  10  beam X (CounterX)
- pix_y  in  10  beam Y (CounterY)
- pix_owner  out  2  owner of the cell under the beam: 00 empty, 01 P1, 10 P2
- busy  out  1  FSM not in IDLE
- step_done  out  1  one-cycle pulse; crash flags valid
- p1_crash  out  1  P1 crashed on the last step; held until the next step_done or clear
- p2_crash  out  1  as above, for P2
- tick_overrun  out  1  sticky; a tick arrived while busy

Behaviour:
- Reset values: pix_owner=0, step_done=0, p1_crash=0, p2_crash=0, tick_overrun=0, state=CLEAR, sweep addr=0, busy=1.
- The RAM itself is not reset. The CLEAR state that follows reset is what guarantees empty cells.
- Cell index = row*COLS + col, giving 0..1199. Each entry is 2 bits.
- FSM states: IDLE, CLEAR, RD1, RD2, EVAL, WR1, WR2, DONE.
- CLEAR:
  - Writes 00 to one address per cycle, from 0 to COLS*ROWS-1.
  - On the last write, goes to IDLE. A reset sweep takes 1200 cycles.
- IDLE transitions:
  - clear_req: sweep addr=0, go to CLEAR, zero p1_crash and p2_crash, zero tick_overrun.
  - Else tick: latch all four head coordinates, go to RD1.
  - clear_req wins over a simultaneous tick. That tick is dropped and does not set tick_overrun.
- RD1 issues the read of the P1 head cell. RD2 issues the P2 head read. The RAM has 1-cycle read latency.
- EVAL:
  - pN out of bounds when col>=COLS or row>=ROWS.
  - p1c = P1 out of bounds OR P1 cell!=00 OR heads equal. p2c is the same rule for P2.
  - Equal heads crash both players.
- WR1 writes 01 at the P1 head unless P1 is out of bounds. WR2 writes 10 at the P2 head unless P2 is out of bounds.
  - Writes happen even when that player crashed, so the head stays visible.
  - When heads are equal, WR2 overwrites WR1, so the cell shows 10.
- DONE: p1_crash<=p1c, p2_crash<=p2c, step_done=1 for one cycle, return to IDLE.
- Latency: tick sampled at edge 0 gives step_done high in the cycle after edge 6.
- tick while busy (any state except IDLE):
  - Dropped; set tick_overrun.
  - Latched coordinates are not disturbed.
- clear_req while busy:
  - In CLEAR it restarts the sweep at 0.
  - Otherwise the current step completes and the clear request is latched pending. CLEAR is entered from DONE instead of IDLE, and step_done still pulses.
- Reset mid-operation aborts any state and restarts CLEAR.
- Pixel port:
  - Stage 1 registers in_area = (pix_x<640 && pix_y<480) and the address (pix_y>>CELL_SHIFT)*COLS + (pix_x>>CELL_SHIFT).
  - Stage 2 reads the RAM. pix_owner = in_area_d ? data : 00.
  - Fixed 2-cycle latency from pix_x/pix_y to pix_owner.
  - The pixel port never stalls. A same-cycle write shows old or new data; either is acceptable, since it resolves by the next frame.

Decomposition:
- Shared package tron_pkg holds:
  - OWN_EMPTY=2'b00, OWN_P1=2'b01, OWN_P2=2'b10.
  - The grid constants COLS, ROWS, CELL_SHIFT.
  - The FSM state encoding.
- One sub-module, tron_cell_ram:
  - Simple dual-port RAM: write/read port A for the game side, read-only port B for the pixel side.
  - Registered reads, 2-bit data, depth COLS*ROWS.
  - Written so it infers block RAM.

Test Plan:
- Reset, then hold idle. Expect busy=1 for exactly 1200 cycles, then 0. A scan of all pix_x/pix_y returns pix_owner=00 everywhere.
- Tick with P1(5,5), P2(20,10) on an empty map. Expect step_done after 7 cycles with both crash flags 0. Pixel (80..95, 80..95) gives 01; pixel (320, 160) gives 10.
- Step P1 again onto (5,5). Expect p1_crash=1, p2_crash=0, and the cell still reads 01.
- Tick with both heads at (12,12). Expect p1_crash=1, p2_crash=1, and the cell reads 10.
- Tick with P1 col=40 (out of bounds). Expect p1_crash=1, no write anywhere, and pix_x=639, pix_y=479 (cell 39,29) unchanged.
- Pulse tick 3 cycles after a prior tick: the step is dropped and tick_overrun=1. Then pulse clear_req: after 1200 cycles all cells read 00 and tick_overrun=0. Separately, assert reset mid-sweep: the sweep restarts and busy stays high a full 1200 cycles after deassertion.
